// File: rtl/sao_stat_accum.sv
//==============================================================================
// Module      : sao_stat_accum
// Description : Per-CTB SAO edge-offset statistics. Sums diffs and counts pixels
//               for categories 1..4, then drains the four (sum,count) pairs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sao_stat_accum #(
    parameter int diff_clip_bit = 4,
    parameter int NUM_PIX       = 4,
    parameter int SUM_BIT       = 18,
    parameter int CNT_BIT       = 13
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_last,
    input  logic [NUM_PIX*(diff_clip_bit+1)-1:0] in_diff,
    input  logic [NUM_PIX*3-1:0]                 in_cat,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [2:0]                           out_cat,
    output logic [SUM_BIT-1:0]                   out_sum,
    output logic [CNT_BIT-1:0]                   out_cnt,
    output logic                                 out_last
);

    localparam int c_dw = diff_clip_bit + 1;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_s1_valid;
    logic [NUM_PIX*c_dw-1:0]    r_s1_diff;
    logic [NUM_PIX*3-1:0]       r_s1_cat;
    logic [SUM_BIT-1:0]         r_sum [4];
    logic [CNT_BIT-1:0]         r_cnt [4];
    logic [1:0]                 r_sel;
    logic [SUM_BIT-1:0]         w_lane_ext [NUM_PIX];
    logic [SUM_BIT-1:0]         w_beat_sum [4];
    logic [CNT_BIT-1:0]         w_beat_cnt [4];
    logic                       w_accept;
    logic                       w_out_fire;
    logic                       w_drain_done;

    for (genvar i = 0; i < NUM_PIX; i++) begin : g_lane
        assign w_lane_ext[i] = {{(SUM_BIT-c_dw){r_s1_diff[i*c_dw+c_dw-1]}},
                                r_s1_diff[i*c_dw +: c_dw]};
    end

    // Per-category contribution of the beat held in S1; cats 0 and 5..7 match nothing.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_beat_sum[k] = '0;
            w_beat_cnt[k] = '0;
            for (int i = 0; i < NUM_PIX; i++) begin
                if (r_s1_cat[i*3 +: 3] == 3'(k + 1)) begin
                    w_beat_sum[k] = w_beat_sum[k] + w_lane_ext[i];
                    w_beat_cnt[k] = w_beat_cnt[k] + CNT_BIT'(1);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && (r_sel == 2'd3)) w_state_nxt = ST_ACC;
            end
            default: w_state_nxt = ST_ACC;
        endcase
    end

    assign w_accept     = in_valid & in_ready;
    assign w_out_fire   = out_valid & out_ready;
    assign w_drain_done = w_out_fire & (r_sel == 2'd3);

    assign out_cat  = {1'b0, r_sel} + 3'd1;
    assign out_sum  = r_sum[r_sel];
    assign out_cnt  = r_cnt[r_sel];
    assign out_last = out_valid & (r_sel == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ACC;
            r_s1_valid <= 1'b0;
            r_s1_diff  <= '0;
            r_s1_cat   <= '0;
            r_sel      <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_diff <= in_diff;
                r_s1_cat  <= in_cat;
            end
            // Index wraps from 3 back to 0 on the final handshake.
            if (w_out_fire) r_sel <= r_sel + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_sum[k] <= '0;
                r_cnt[k] <= '0;
            end
        end else if (w_drain_done) begin
            for (int k = 0; k < 4; k++) begin
                r_sum[k] <= '0;
                r_cnt[k] <= '0;
            end
        end else if (r_s1_valid) begin
            for (int k = 0; k < 4; k++) begin
                r_sum[k] <= r_sum[k] + w_beat_sum[k];
                r_cnt[k] <= r_cnt[k] + w_beat_cnt[k];
            end
        end
    end

endmodule

`default_nettype wire
